// File: rtl/lights_pkg.sv
// Shared types and helpers for the pedestrian-light block family.
// The light controller uses the same state encoding.
package lights_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVING = 2'd2
  } ped_state_t;

  // Bits needed to count up to (value-1); never below 1 so a counter always exists.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a level debouncer: the stable level only
// follows the synchronized button after DebCycles consecutive differing samples.
module debouncer
  import lights_pkg::*;
#(
  parameter int DebCycles = 10
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Button,
  output logic Stable
);

  localparam int CntW = clog2(DebCycles);

  logic            sync1_q;
  logic            sync2_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= Button;
      sync2_q <= sync1_q;
    end
  end

  // Any sample agreeing with the stable level restarts the run, so glitches vanish.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      Stable <= 1'b0;
    end else if (sync2_q == Stable) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(DebCycles - 1)) begin
      Stable <= sync2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ped_request.sv
// Pedestrian push-button front end: debounced press pulse, request latch
// towards the light controller and an acknowledge beep (active-low).
module ped_request
  import lights_pkg::*;
#(
  parameter int ClockPeriod_ns = 20,
  parameter int Debounce_ns    = 10_000_000,
  parameter int BeepHold_ns    = 100_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Button,
  input  logic       Grant,
  output logic       Request,
  output logic       Press,
  output logic       Beep,
  output ped_state_t State
);

  localparam int DebCycles  = Debounce_ns / ClockPeriod_ns;
  localparam int BeepCycles = BeepHold_ns / ClockPeriod_ns;
  localparam int BeepW      = clog2(BeepCycles + 1);

  generate
    if (DebCycles < 2 || BeepCycles < 2) begin : g_bad_timing
      $error("ped_request: DebCycles and BeepCycles must both be at least 2");
    end
  endgenerate

  logic             stable;
  logic             stable_q;
  ped_state_t       state_q;
  ped_state_t       state_d;
  logic [BeepW-1:0] beep_cnt_q;

  debouncer #(
    .DebCycles(DebCycles)
  ) u_debouncer (
    .Clock  (Clock),
    .Reset  (Reset),
    .Button (Button),
    .Stable (stable)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) stable_q <= 1'b0;
    else       stable_q <= stable;
  end

  // Rising edge of the stable level only; releases give no pulse.
  assign Press = stable & ~stable_q;

  // Grant wins over a simultaneous press in IDLE, so no request is raised then.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Grant)      state_d = SERVING;
        else if (Press) state_d = ARMED;
      end
      ARMED: begin
        if (Grant) state_d = SERVING;
      end
      SERVING: begin
        if (!Grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Every press restarts the full beep, so overlapping presses never leave a gap.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      beep_cnt_q <= '0;
    end else if (Press) begin
      beep_cnt_q <= BeepW'(BeepCycles);
    end else if (beep_cnt_q != '0) begin
      beep_cnt_q <= beep_cnt_q - 1'b1;
    end
  end

  assign Request = (state_q == ARMED);
  assign Beep    = (beep_cnt_q == '0);
  assign State   = state_q;

endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: directed scenarios plus random button/grant traffic,
// all checked cycle by cycle against a sample-history reference model.
module tb_ped_request;
  import lights_pkg::*;

  localparam int DEB  = 10;
  localparam int BEEP = 20;
  localparam int LAT  = DEB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic       grant = 1'b0;
  logic       request;
  logic       press;
  logic       beep;
  ped_state_t state;

  always #10 clk = ~clk;

  ped_request #(
    .ClockPeriod_ns (20),
    .Debounce_ns    (200),
    .BeepHold_ns    (400)
  ) dut (
    .Clock   (clk),
    .Reset   (rst),
    .Button  (button),
    .Grant   (grant),
    .Request (request),
    .Press   (press),
    .Beep    (beep),
    .State   (state)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: button samples taken at each edge, newest first.
  bit          hist[$];
  logic        m_stable;
  logic        m_press;
  ped_state_t  m_state;
  int          cyc = 0;
  int          beep_until = -1;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back(1'b0);
    m_stable   = 1'b0;
    m_press    = 1'b0;
    m_state    = IDLE;
    beep_until = -1;
    exp_q.delete();
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      logic old_stable;
      logic p_prev;
      bit   all_diff;
      cyc++;
      p_prev = m_press;
      hist.push_front(button);
      void'(hist.pop_back());
      // Level flips once the synchronized samples disagreed for DEB edges in a row.
      old_stable = m_stable;
      all_diff   = 1'b1;
      for (int i = 2; i < LAT; i++) if (hist[i] == m_stable) all_diff = 1'b0;
      if (all_diff) m_stable = ~m_stable;
      case (m_state)
        IDLE:    if (grant) m_state = SERVING; else if (p_prev) m_state = ARMED;
        ARMED:   if (grant) m_state = SERVING;
        default: if (!grant) m_state = IDLE;
      endcase
      if (p_prev) beep_until = cyc - 1 + BEEP;
      m_press = m_stable & ~old_stable;
      if (m_press) exp_q.push_back(cyc);
    end
  end

  int   win_press = 0;
  int   win_beep_low = 0;
  int   win_beep_fall = 0;
  int   win_req = 0;
  logic prev_beep = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      check("press", press, m_press);
      check("beep", beep, (cyc <= beep_until) ? 1'b0 : 1'b1);
      check("request", request, m_state == ARMED);
      check("state", state, m_state);
      if (press) begin
        if (exp_q.size() > 0) check("press_cycle", cyc, exp_q.pop_front());
        else                  check("press_unexpected", press, 1'b0);
      end
      win_press    += int'(press);
      win_req      += int'(request);
      if (!beep) win_beep_low++;
      if (prev_beep && !beep) win_beep_fall++;
      prev_beep = beep;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_win();
    win_press     = 0;
    win_beep_low  = 0;
    win_beep_fall = 0;
    win_req       = 0;
  endtask

  // Bounded wait for a press; the latency is counted in clock cycles.
  task automatic wait_press(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (n < 200) begin
      tick(1);
      n++;
      if (press) break;
    end
    check(tag, n, exp_lat);
  endtask

  initial begin
    tick(3);
    check("reset_beep", beep, 1'b1);
    check("reset_request", request, 1'b0);
    check("reset_press", press, 1'b0);
    check("reset_state", state, IDLE);
    rst = 1'b0;
    tick(2);

    // Clean press held 30 cycles with no grant.
    clear_win();
    button = 1'b1;
    wait_press("clean_latency", LAT);
    tick(30 - LAT);
    button = 1'b0;
    tick(40);
    check("clean_press_count", win_press, 1);
    check("clean_beep_len", win_beep_low, BEEP);
    check("clean_beep_edges", win_beep_fall, 1);
    check("clean_armed", state, ARMED);

    // Grant while armed, then a press during the grant.
    grant = 1'b1;
    tick(1);
    check("grant_drops_request", request, 1'b0);
    clear_win();
    button = 1'b1;
    wait_press("serving_press_latency", LAT);
    tick(12);
    button = 1'b0;
    tick(30);
    check("serving_beep_len", win_beep_low, BEEP);
    check("serving_no_request", win_req, 0);
    grant = 1'b0;
    tick(1);
    check("serving_to_idle", state, IDLE);

    // Bouncing input never reaches a full debounce window.
    clear_win();
    repeat (4) begin
      button = 1'b1;
      tick(5);
      button = 1'b0;
      tick(3);
    end
    tick(20);
    check("glitch_press", win_press, 0);
    check("glitch_request", win_req, 0);
    check("glitch_beep", win_beep_low, 0);

    // Grant rising in the same cycle as the press in IDLE.
    clear_win();
    button = 1'b1;
    wait_press("coincide_latency", LAT);
    grant = 1'b1;
    tick(10);
    button = 1'b0;
    tick(15);
    check("coincide_no_request", win_req, 0);
    check("coincide_serving", state, SERVING);
    grant = 1'b0;
    tick(1);
    check("coincide_idle", state, IDLE);
    button = 1'b1;
    wait_press("rearm_latency", LAT);
    tick(2);
    check("rearm_request", request, 1'b1);
    button = 1'b0;
    tick(15);
    grant = 1'b1;
    tick(2);
    grant = 1'b0;
    tick(12);

    // Second press arriving exactly as the first beep ends: one continuous beep.
    clear_win();
    button = 1'b1;
    tick(DEB);
    button = 1'b0;
    tick(DEB);
    button = 1'b1;
    tick(25);
    button = 1'b0;
    tick(30);
    check("retrigger_presses", win_press, 2);
    check("retrigger_beep_len", win_beep_low, 2 * BEEP);
    check("retrigger_beep_edges", win_beep_fall, 1);

    // Asynchronous reset mid-beep while armed, button held through release.
    button = 1'b1;
    wait_press("pre_reset_latency", LAT);
    tick(5);
    check("pre_reset_request", request, 1'b1);
    check("pre_reset_beep", beep, 1'b0);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_beep", beep, 1'b1);
    check("async_reset_request", request, 1'b0);
    check("async_reset_state", state, IDLE);
    tick(2);
    rst = 1'b0;
    wait_press("post_reset_latency", LAT);
    button = 1'b0;
    tick(30);

    // Random traffic.
    repeat (150) begin
      button = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) grant = ~grant;
      tick($urandom_range(1, 25));
    end
    button = 1'b0;
    grant  = 1'b0;
    tick(40);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
